// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state type and operand-signedness helpers.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the core control path and the
// multiply/divide unit; the core is the master, the unit the slave.
interface muldiv_if #(
  parameter int XLEN = 32
);
  import muldiv_pkg::*;

  logic            Start;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] RURs1;
  logic [XLEN-1:0] RURs2;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] Result;

  modport master (
    output Start, Funct3, RURs1, RURs2,
    input  Busy, Done, Result
  );

  modport slave (
    input  Start, Funct3, RURs1, RURs2,
    output Busy, Done, Result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one shift-add or restoring-divide step
// per cycle on operand magnitudes, signs applied in a final fixup cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     state_reg;
  logic [2:0]        f3_reg;
  logic [XLEN-1:0]   a_mag_reg;
  logic [XLEN-1:0]   b_mag_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [CW-1:0]     cnt_reg;
  logic              sign_res_reg;
  logic              sign_a_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [XLEN-1:0]   result_reg;

  // Start-time decode of operand magnitudes and corner cases
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, special;
  logic [2*XLEN-1:0] special_acc;

  always_comb begin
    a_neg       = a_signed(bus.Funct3) & bus.RURs1[XLEN-1];
    b_neg       = b_signed(bus.Funct3) & bus.RURs2[XLEN-1];
    a_mag       = a_neg ? -bus.RURs1 : bus.RURs1;
    b_mag       = b_neg ? -bus.RURs2 : bus.RURs2;
    div_zero    = (bus.RURs2 == '0);
    div_ovf     = ((bus.Funct3 == F3_DIV) || (bus.Funct3 == F3_REM)) &&
                  (bus.RURs1 == MIN_NEG) && (&bus.RURs2);
    special     = is_div(bus.Funct3) && (div_zero || div_ovf);
    // Preload so the normal FIX path yields the architected result:
    // remainder half = |dividend| (re-signed in FIX), quotient half = all ones / MIN.
    special_acc = div_zero ? {a_mag, {XLEN{1'b1}}} : {{XLEN{1'b0}}, MIN_NEG};
  end

  // One iteration step, MSB-first, using the counter as the bit index of A
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     rem_sub;
  logic              q_bit;
  logic [XLEN-1:0]   rem_new;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    mul_next  = {acc_reg[2*XLEN-2:0], 1'b0} +
                (a_mag_reg[cnt_reg] ? {{XLEN{1'b0}}, b_mag_reg} : '0);
    rem_shift = {acc_reg[2*XLEN-1:XLEN], a_mag_reg[cnt_reg]};
    rem_sub   = rem_shift - {1'b0, b_mag_reg};
    q_bit     = (rem_shift >= {1'b0, b_mag_reg});
    rem_new   = q_bit ? rem_sub[XLEN-1:0] : rem_shift[XLEN-1:0];
    div_next  = {rem_new, acc_reg[XLEN-2:0], q_bit};
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_result;

  always_comb begin
    prod = sign_res_reg ? -acc_reg : acc_reg;
    quo  = sign_res_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
    rem  = sign_a_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
    case (f3_reg)
      F3_MUL:              fix_result = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU,
      F3_MULHU:            fix_result = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:     fix_result = quo;
      default:             fix_result = rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      f3_reg       <= '0;
      a_mag_reg    <= '0;
      b_mag_reg    <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      sign_res_reg <= 1'b0;
      sign_a_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      result_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.Start) begin
            f3_reg       <= bus.Funct3;
            a_mag_reg    <= a_mag;
            b_mag_reg    <= b_mag;
            sign_a_reg   <= a_neg;
            // Special quotients are already final; never re-sign them
            sign_res_reg <= special ? 1'b0 : (a_neg ^ b_neg);
            cnt_reg      <= CW'(XLEN - 1);
            busy_reg     <= 1'b1;
            acc_reg      <= special ? special_acc : '0;
            state_reg    <= special ? FIX : CALC;
          end
        end
        CALC: begin
          acc_reg <= is_div(f3_reg) ? div_next : mul_next;
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == '0) state_reg <= FIX;
        end
        FIX: begin
          result_reg <= fix_result;
          done_reg   <= 1'b1;
          busy_reg   <= 1'b0;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.Busy   = busy_reg;
  assign bus.Done   = done_reg;
  assign bus.Result = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expectations queued at Start,
// popped and compared when Done arrives.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } sb_item_t;

  sb_item_t sb[$];

  muldiv_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Independent reference using native SV signed/unsigned arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb_v;
    sa = a;
    sb_v = b;
    case (f3)
      F3_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      F3_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      F3_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      F3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      F3_DIV:    if (b == 0) return 32'hFFFF_FFFF;
                 else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                 else return 32'(sa / sb_v);
      F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM:    if (b == 0) return a;
                 else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                 else return 32'(sa % sb_v);
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0)) return 1;
    if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Caller positions itself away from the clock edge; returns #1 after the Done edge
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit disturb);
    sb_item_t it;
    int edges;
    int busy_cnt;
    bit got;
    bus.Start  = 1'b1;
    bus.Funct3 = f3;
    bus.RURs1  = a;
    bus.RURs2  = b;
    it.res = exp;
    it.lat = lat;
    sb.push_back(it);
    @(posedge clk); #1;
    bus.Start = 1'b0;
    busy_cnt = bus.Busy ? 1 : 0;
    edges = 0;
    got = 1'b0;
    while (!got && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (bus.Done) got = 1'b1;
      else if (bus.Busy) busy_cnt++;
      if (disturb) begin
        if (edges == 5) begin
          bus.Start  = 1'b1;
          bus.Funct3 = F3_DIVU;
          bus.RURs1  = $urandom;
          bus.RURs2  = $urandom;
        end else if (edges == 6) begin
          bus.Start = 1'b0;
        end
        if (edges == 10) bus.RURs1 = $urandom;
      end
    end
    it = sb.pop_front();
    check({tag, "_done"}, 64'(got), 64'd1);
    if (got) begin
      check({tag, "_res"}, 64'(bus.Result), 64'(it.res));
      check({tag, "_lat"}, 64'(edges), 64'(it.lat));
      check({tag, "_busy"}, 64'(busy_cnt), 64'(it.lat));
    end
  endtask

  initial begin
    int done_seen;
    logic [31:0] ra, rb;
    logic [2:0]  rf;

    bus.Start  = 1'b0;
    bus.Funct3 = '0;
    bus.RURs1  = '0;
    bus.RURs2  = '0;
    rst_n = 1'b0;
    #12;
    check("rst_busy", 64'(bus.Busy), 64'd0);
    check("rst_done", 64'(bus.Done), 64'd0);
    check("rst_result", 64'(bus.Result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    run_op("mul", F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0);
    @(posedge clk); #1;
    check("mul_done_pulse", 64'(bus.Done), 64'd0);

    @(negedge clk);
    run_op("mulh", F3_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0);
    @(negedge clk);
    run_op("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
    @(negedge clk);
    run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0);
    @(negedge clk);
    run_op("div", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
    @(negedge clk);
    run_op("rem", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
    @(negedge clk);
    run_op("divu", F3_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    @(negedge clk);
    run_op("remu", F3_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b0);

    @(negedge clk);
    run_op("divu0", F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    @(negedge clk);
    run_op("remu0", F3_REMU, 32'd5, 32'd0, 32'd5, 1, 1'b0);
    @(negedge clk);
    run_op("div0s", F3_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    @(negedge clk);
    run_op("rem0s", F3_REM, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 1, 1'b0);
    @(negedge clk);
    run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    @(negedge clk);
    run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);

    // Busy-time Start and operand changes must be ignored
    @(negedge clk);
    run_op("mul_dist", F3_MUL, 32'd1234, 32'd5678, 32'd7006652, 33, 1'b1);

    // Back-to-back: second Start issued in the Done cycle of the first
    @(negedge clk);
    run_op("b2b_a", F3_MULHU, 32'hDEAD_BEEF, 32'h1234_5678,
           ref_op(F3_MULHU, 32'hDEAD_BEEF, 32'h1234_5678), 33, 1'b0);
    run_op("b2b_b", F3_REM, 32'hFFFF_FC18, 32'd7, 32'hFFFF_FFFA, 33, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom;
      if (i == 5) rb = 32'd3;
      @(negedge clk);
      run_op($sformatf("rnd%0d_f%0d", i, rf), rf, ra, rb, ref_op(rf, ra, rb), ref_lat(rf, ra, rb), 1'b0);
    end

    // Reset abort in the middle of a divide
    @(negedge clk);
    bus.Start  = 1'b1;
    bus.Funct3 = F3_DIV;
    bus.RURs1  = 32'd1000;
    bus.RURs2  = 32'd3;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.Busy), 64'd0);
    check("abort_done", 64'(bus.Done), 64'd0);
    check("abort_result", 64'(bus.Result), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.Done) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);

    @(negedge clk);
    run_op("post_rst_mul", F3_MUL, 32'd3, 32'd4, 32'd12, 33, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
